cordic_phase_sequencer: RTL and testbench

- Control stage that sits directly in front of the iterative sine/cosine CORDIC core and also collects its results.
- Accepts a full-circle unsigned phase word and folds it into the core's convergence range of ±pi/2.
- Scales the folded phase to radians in Q2.14, issues a one-cycle load to the core, then waits for done.
- Applies the quadrant sign correction and presents the final cos/sin with a one-cycle valid; includes a done watchdog.

---
 rtl/cordic_pkg.sv | 23 ++
 rtl/cordic_quadrant_fold.sv | 24 ++
 rtl/cordic_phase_sequencer.sv | 122 ++++++++++++
 tb/tb_cordic_phase_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared constants and state encoding for the CORDIC phase sequencer slice.
package cordic_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SCALE = 3'd1;
  localparam logic [2:0] ST_ISSUE = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_FIX   = 3'd4;

  typedef enum logic [2:0] {
    StIdle  = ST_IDLE,
    StScale = ST_SCALE,
    StIssue = ST_ISSUE,
    StWait  = ST_WAIT,
    StFix   = ST_FIX
  } cordic_state_e;

  localparam int QUARTER_TURN = 16384;
  localparam int HALF_TURN    = 32768;
  localparam int HALF_PI_Q14  = 25736;
  localparam int Q14_ONE      = 16384;

endpackage

// File: rtl/cordic_quadrant_fold.sv
// Folds a full-circle phase word into [-quarter, +quarter] turn and flags a
// cosine sign flip for the two outer quadrants.
module cordic_quadrant_fold
  import cordic_pkg::*;
(
  input  logic [15:0] phase,
  output logic [15:0] fold,
  output logic        neg_cos
);

  localparam logic signed [15:0] Quarter = 16'(QUARTER_TURN);
  localparam logic [15:0]        Half    = 16'(HALF_TURN);

  logic signed [15:0] s;

  always_comb begin
    s       = $signed(phase);
    neg_cos = (s > Quarter) || (s < -Quarter);
    // Both outer branches reduce to half_turn - s modulo 2^16; the result
    // always lands in range, so the wrap is harmless.
    fold    = neg_cos ? (Half - phase) : phase;
  end

endmodule

// File: rtl/cordic_phase_sequencer.sv
// Front-end sequencer for the iterative sin/cos CORDIC core: folds and scales
// the phase, loads the core, waits for done with a watchdog, fixes the sign.
module cordic_phase_sequencer #(
  parameter int unsigned TIMEOUT     = 63,
  parameter int          HALF_PI_Q14 = cordic_pkg::HALF_PI_Q14
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] phase,
  output logic        busy,
  output logic        c_load,
  output logic [15:0] c_angle,
  input  logic        c_done,
  input  logic [15:0] c_co,
  input  logic [15:0] c_so,
  output logic        valid,
  output logic [15:0] cos_out,
  output logic [15:0] sin_out,
  output logic        err
);
  import cordic_pkg::*;

  localparam logic signed [31:0] MultK   = 32'(HALF_PI_Q14);
  localparam logic [7:0]         WdLimit = 8'(TIMEOUT);

  cordic_state_e      state;
  logic [15:0]        fold;
  logic               neg_cos;
  logic signed [15:0] fold_q;
  logic               neg_cos_q;
  logic [7:0]         wd_q;
  logic [7:0]         wd_inc;
  logic signed [15:0] co_q;
  logic signed [15:0] so_q;
  logic signed [15:0] angle_next;
  logic signed [15:0] cos_fixed;

  cordic_quadrant_fold u_fold (
    .phase   (phase),
    .fold    (fold),
    .neg_cos (neg_cos)
  );

  // Floor of fold * pi/2 in Q2.14; |fold| <= 2^14 keeps this within 16 bits.
  assign angle_next = 16'((32'(fold_q) * MultK) >>> 14);
  assign wd_inc     = wd_q + 8'd1;

  always_comb begin
    cos_fixed = co_q;
    if (neg_cos_q) begin
      cos_fixed = (co_q == 16'sh8000) ? 16'sh7fff : -co_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= StIdle;
      busy      <= 1'b0;
      c_load    <= 1'b0;
      c_angle   <= '0;
      valid     <= 1'b0;
      err       <= 1'b0;
      cos_out   <= '0;
      sin_out   <= '0;
      fold_q    <= '0;
      neg_cos_q <= 1'b0;
      wd_q      <= '0;
      co_q      <= '0;
      so_q      <= '0;
    end else begin
      c_load <= 1'b0;
      valid  <= 1'b0;
      err    <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start) begin
            fold_q    <= $signed(fold);
            neg_cos_q <= neg_cos;
            busy      <= 1'b1;
            state     <= StScale;
          end
        end
        StScale: begin
          c_angle <= angle_next;
          c_load  <= 1'b1;
          state   <= StIssue;
        end
        StIssue: begin
          wd_q  <= '0;
          state <= StWait;
        end
        StWait: begin
          if (c_done) begin
            co_q  <= $signed(c_co);
            so_q  <= $signed(c_so);
            state <= StFix;
          end else begin
            wd_q <= wd_inc;
            if (wd_inc == WdLimit) begin
              err   <= 1'b1;
              busy  <= 1'b0;
              state <= StIdle;
            end
          end
        end
        StFix: begin
          cos_out <= cos_fixed;
          sin_out <= so_q;
          valid   <= 1'b1;
          busy    <= 1'b0;
          state   <= StIdle;
        end
        default: begin
          busy  <= 1'b0;
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_phase_sequencer.sv
// Directed bench for cordic_phase_sequencer with a fixed-latency core stub.
module tb_cordic_phase_sequencer;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               start = 1'b0;
  logic [15:0]        phase = '0;
  logic               busy;
  logic               c_load;
  logic signed [15:0] c_angle;
  logic               c_done;
  logic signed [15:0] c_co;
  logic signed [15:0] c_so;
  logic               valid;
  logic signed [15:0] cos_out;
  logic signed [15:0] sin_out;
  logic               err;

  int n_cmp  = 0;
  int n_fail = 0;

  // Core stub: done rises 41 cycles after load and stays high until next load.
  logic               stub_done;
  logic signed [15:0] stub_co = '0;
  logic signed [15:0] stub_so = '0;
  bit                 stub_en = 1'b1;
  int                 stub_cnt;

  assign c_done = stub_done;
  assign c_co   = stub_co;
  assign c_so   = stub_so;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stub_cnt  <= 0;
      stub_done <= 1'b0;
    end else if (c_load) begin
      stub_cnt  <= 41;
      stub_done <= 1'b0;
    end else if (stub_cnt != 0) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == 1) stub_done <= stub_en;
    end
  end

  cordic_phase_sequencer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .phase   (phase),
    .busy    (busy),
    .c_load  (c_load),
    .c_angle (c_angle),
    .c_done  (c_done),
    .c_co    (c_co),
    .c_so    (c_so),
    .valid   (valid),
    .cos_out (cos_out),
    .sin_out (sin_out),
    .err     (err)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL global_timeout sim ran past 1ms, want finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step();
    step();
    n_cmp++;
    if ({busy, c_load, valid, err} !== 4'b0 || c_angle !== 16'sd0 || cos_out !== 16'sd0
        || sin_out !== 16'sd0) begin
      n_fail++;
      $display("FAIL reset busy/load/valid/err got %b angle %0d cos %0d sin %0d want all 0",
               {busy, c_load, valid, err}, c_angle, cos_out, sin_out);
    end
    reset_n = 1'b1;
    step();
  endtask

  // Full transaction from IDLE; returns after valid (or budget expiry) plus a few idle cycles.
  task automatic run_txn(input string name, input logic [15:0] ph,
                         input logic signed [15:0] co, input logic signed [15:0] so,
                         input logic signed [15:0] exp_ang, input logic signed [15:0] exp_cos,
                         input logic signed [15:0] exp_sin);
    int loads = 0, valids = 0, errs = 0;
    logic signed [15:0] got_cos = 'x, got_sin = 'x, got_ang = 'x;
    stub_co = co;
    stub_so = so;
    stub_en = 1'b1;
    phase   = ph;
    start   = 1'b1;
    step();
    start = 1'b0;
    phase = 16'h1357;
    n_cmp++;
    if (c_load !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s cycle1 c_load %b busy %b want 0 1", name, c_load, busy);
    end
    step();
    n_cmp++;
    if (c_load !== 1'b1 || c_angle !== exp_ang) begin
      n_fail++;
      $display("FAIL %s cycle2 c_load %b c_angle %0d want 1 %0d", name, c_load, c_angle, exp_ang);
    end
    for (int i = 0; i < 100 && valids == 0; i++) begin
      step();
      if (c_load) loads++;
      if (err) errs++;
      if (valid) begin
        valids++;
        got_cos = cos_out;
        got_sin = sin_out;
        got_ang = c_angle;
      end
    end
    for (int i = 0; i < 3; i++) begin
      step();
      if (valid) valids++;
      if (c_load) loads++;
      if (err) errs++;
    end
    n_cmp++;
    if (valids != 1 || loads != 0 || errs != 0) begin
      n_fail++;
      $display("FAIL %s strobes valid %0d extra_load %0d err %0d want 1 0 0",
               name, valids, loads, errs);
    end
    n_cmp++;
    if (got_cos !== exp_cos || got_sin !== exp_sin) begin
      n_fail++;
      $display("FAIL %s result cos %0d sin %0d want %0d %0d",
               name, got_cos, got_sin, exp_cos, exp_sin);
    end
    n_cmp++;
    if (got_ang !== exp_ang || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s end c_angle %0d busy %b want %0d 0", name, got_ang, busy, exp_ang);
    end
  endtask

  task automatic test_quadrants();
    run_txn("ph_0000", 16'h0000, 16384, 0, 0, 16384, 0);
    run_txn("ph_4000", 16'h4000, 0, 16384, 25736, 0, 16384);
    run_txn("ph_6000", 16'h6000, 11585, 11585, 12868, -11585, 11585);
    run_txn("ph_8000", 16'h8000, 16384, 0, 0, -16384, 0);
    run_txn("ph_A000", 16'hA000, 11585, -11585, -12868, -11585, -11585);
    run_txn("ph_C000", 16'hC000, 0, -16384, -25736, 0, -16384);
    run_txn("ph_4001", 16'h4001, 5, 7, 25734, -5, 7);
    run_txn("ph_BFFF", 16'hBFFF, 100, -200, -25735, -100, -200);
  endtask

  task automatic test_neg_saturate();
    run_txn("neg_sat", 16'h6000, -32768, 0, 12868, 32767, 0);
  endtask

  // Relies on the previous result being cos 32767 / sin 0.
  task automatic test_timeout();
    int k = 0, valids = 0;
    bit seen = 1'b0;
    stub_en = 1'b0;
    phase   = 16'h2000;
    start   = 1'b1;
    step();
    start = 1'b0;
    step();
    for (int i = 0; i < 200 && !seen; i++) begin
      step();
      k++;
      if (valid) valids++;
      if (err) seen = 1'b1;
    end
    n_cmp++;
    if (!seen || k != 64) begin
      n_fail++;
      $display("FAIL timeout err_seen %b at cycle %0d after load, want 1 at 64", seen, k);
    end
    n_cmp++;
    if (busy !== 1'b0 || valids != 0 || cos_out !== 16'sd32767 || sin_out !== 16'sd0) begin
      n_fail++;
      $display("FAIL timeout_state busy %b valid %0d cos %0d sin %0d want 0 0 32767 0",
               busy, valids, cos_out, sin_out);
    end
    step();
    n_cmp++;
    if (err !== 1'b0 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_pulse err %b valid %b want 0 0", err, valid);
    end
    stub_en = 1'b1;
  endtask

  task automatic test_start_mid_wait();
    int valids = 0, loads = 0;
    stub_co = 16384;
    stub_so = 0;
    phase   = 16'h0000;
    start   = 1'b1;
    step();
    start = 1'b0;
    step();
    for (int i = 0; i < 10; i++) step();
    phase = 16'h4000;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 120; i++) begin
      step();
      if (c_load) loads++;
      if (valid) begin
        valids++;
        n_cmp++;
        if (cos_out !== 16'sd16384 || sin_out !== 16'sd0 || c_angle !== 16'sd0) begin
          n_fail++;
          $display("FAIL mid_wait result cos %0d sin %0d angle %0d want 16384 0 0",
                   cos_out, sin_out, c_angle);
        end
      end
    end
    n_cmp++;
    if (valids != 1 || loads != 0) begin
      n_fail++;
      $display("FAIL mid_wait strobes valid %0d extra_load %0d want 1 0", valids, loads);
    end
  endtask

  task automatic test_back_to_back();
    bit seen = 1'b0;
    int valids = 0;
    stub_co = 11585;
    stub_so = 11585;
    phase   = 16'h6000;
    start   = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      step();
      if (valid) seen = 1'b1;
    end
    // Start raised in the valid cycle; state is IDLE there.
    stub_co = 0;
    stub_so = 16384;
    phase   = 16'h4000;
    start   = 1'b1;
    step();
    start = 1'b0;
    n_cmp++;
    if (!seen || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_accept first_valid %b busy %b want 1 1", seen, busy);
    end
    for (int i = 0; i < 100 && valids == 0; i++) begin
      step();
      if (valid) begin
        valids++;
        n_cmp++;
        if (cos_out !== 16'sd0 || sin_out !== 16'sd16384 || c_angle !== 16'sd25736) begin
          n_fail++;
          $display("FAIL b2b_result cos %0d sin %0d angle %0d want 0 16384 25736",
                   cos_out, sin_out, c_angle);
        end
      end
    end
    n_cmp++;
    if (valids != 1) begin
      n_fail++;
      $display("FAIL b2b_second valid count %0d want 1", valids);
    end
    step();
  endtask

  task automatic test_reset_mid_wait();
    stub_co = 777;
    stub_so = 888;
    phase   = 16'h2000;
    start   = 1'b1;
    step();
    start = 1'b0;
    step();
    for (int i = 0; i < 5; i++) step();
    #1;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, c_load, valid, err} !== 4'b0 || c_angle !== 16'sd0 || cos_out !== 16'sd0
        || sin_out !== 16'sd0) begin
      n_fail++;
      $display("FAIL reset_mid_wait busy/load/valid/err %b angle %0d cos %0d sin %0d want 0",
               {busy, c_load, valid, err}, c_angle, cos_out, sin_out);
    end
    step();
    reset_n = 1'b1;
    step();
    run_txn("post_reset", 16'h2000, 777, 888, 12868, 777, 888);
  endtask

  initial begin
    test_reset();
    test_quadrants();
    test_neg_saturate();
    test_timeout();
    test_start_mid_wait();
    test_back_to_back();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
